// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock: ring FSM states, BCD field limits,
// digit-packing offsets of the 24-bit {hour,min,sec} word and the 12-hour display helper.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int SEC_OFS  = 0;
  localparam int MIN_OFS  = 8;
  localparam int HOUR_OFS = 16;

  // 24-hour BCD hour (00..23) to 12-hour BCD hour (01..12)
  function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
    logic [4:0] bin;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (bin == 5'd0)       bin = 5'd12;
    else if (bin > 5'd12)  bin = bin - 5'd12;
    if (bin >= 5'd10) return {4'd1, 4'(bin - 5'd10)};
    return {4'd0, 4'(bin)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter 00..MAX wrapping to 00; carry flags the wrapping increment.
// Latency: value updates on the edge sampling inc; carry is combinational. No backpressure.
// Always accepts inc.
module bcd2_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'h00;
    end else if (inc) begin
      if (q == MAX)             q <= 8'h00;
      else if (q[3:0] == 4'd9)  q <= {q[7:4] + 4'd1, 4'd0};
      else                      q <= q + 8'd1;
    end
  end

endmodule

// File: rtl/alarm_clock_core.sv
// Alarm clock datapath: time counter, NUM_ALARMS alarms, compare and ring/snooze FSM.
// Latency: time updates on the tick edge, ringing rises two clk after the tick.
// No backpressure: all pulses are consumed in the cycle they arrive. ALARM_CLOCK_12H_EN selects 12-hour display.
module alarm_clock_core
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SEL_W        = 2,
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_TIMEOUT = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic                  set_time,
  input  logic                  up_sec,
  input  logic                  up_min,
  input  logic                  up_hour,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  alarm_up_sec,
  input  logic                  alarm_up_min,
  input  logic                  alarm_up_hour,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_bcd,
  output logic [23:0]           alarm_bcd,
  output logic                  pm,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [SEL_W-1:0]      ring_id,
  output logic [1:0]            state
);

  localparam int RW = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  logic [7:0]  sec_q, min_q, hour_q;
  logic        sec_carry, min_carry, hour_carry_unused;
  logic [23:0] time_q;

  // In set mode each field takes only its own pulse, so carries never propagate
  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc(set_time ? up_sec : tick_1hz),
    .q(sec_q), .carry(sec_carry));
  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc(set_time ? up_min : sec_carry),
    .q(min_q), .carry(min_carry));
  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .reset(reset), .inc(set_time ? up_hour : min_carry),
    .q(hour_q), .carry(hour_carry_unused));

  assign time_q = {hour_q, min_q, sec_q};

  logic [NUM_ALARMS-1:0][23:0]  alarm_q;
  logic [3*NUM_ALARMS-1:0]      alarm_carry_unused;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
    logic       hit;
    logic [7:0] a_sec, a_min, a_hour;
    assign hit = (alarm_sel == SEL_W'(gi));
    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .reset(reset), .inc(alarm_up_sec && hit),
      .q(a_sec), .carry(alarm_carry_unused[3*gi]));
    bcd2_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .reset(reset), .inc(alarm_up_min && hit),
      .q(a_min), .carry(alarm_carry_unused[3*gi+1]));
    bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk(clk), .reset(reset), .inc(alarm_up_hour && hit),
      .q(a_hour), .carry(alarm_carry_unused[3*gi+2]));
    assign alarm_q[gi] = {a_hour, a_min, a_sec};
  end

  logic [23:0]      alarm_view;
  logic             match, ring_en;
  logic [SEL_W-1:0] match_id;

  always_comb begin
    alarm_view = '0;
    match      = 1'b0;
    match_id   = '0;
    ring_en    = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_sel == SEL_W'(i)) alarm_view = alarm_q[i];
      if (ring_id == SEL_W'(i))   ring_en    = alarm_en[i];
    end
    // descending scan so the lowest matching index wins
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && (alarm_q[i] == time_q)) begin
        match    = 1'b1;
        match_id = SEL_W'(i);
      end
    end
  end

  ring_state_t      cur_state, nxt_state;
  logic [SEL_W-1:0] nxt_id;
  logic [RW-1:0]    ring_cnt, nxt_ring;
  logic [SW-1:0]    snz_cnt, nxt_snz;
  logic             adv_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      ring_id   <= '0;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      adv_d     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      ring_id   <= nxt_id;
      ring_cnt  <= nxt_ring;
      snz_cnt   <= nxt_snz;
      adv_d     <= tick_1hz && !set_time;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_id    = ring_id;
    nxt_ring  = ring_cnt;
    nxt_snz   = snz_cnt;
    case (cur_state)
      IDLE: begin
        if (adv_d && match) begin
          nxt_state = RING;
          nxt_id    = match_id;
          nxt_ring  = '0;
        end
      end
      RING: begin
        if (dismiss || !ring_en) begin
          nxt_state = IDLE;
        end else if (snooze) begin
          nxt_state = SNOOZE;
          nxt_snz   = SW'(SNOOZE_SEC);
        end else if (tick_1hz) begin
          if (ring_cnt == RW'(RING_TIMEOUT - 1)) nxt_state = IDLE;
          else                                   nxt_ring  = ring_cnt + RW'(1);
        end
      end
      SNOOZE: begin
        if (dismiss || !ring_en) begin
          nxt_state = IDLE;
        end else if (tick_1hz) begin
          nxt_snz = snz_cnt - SW'(1);
          if (snz_cnt <= SW'(1)) begin
            nxt_state = RING;
            nxt_ring  = '0;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign state    = cur_state;
  assign ringing  = (cur_state == RING);
  assign snoozing = (cur_state == SNOOZE);

`ifdef ALARM_CLOCK_12H_EN
  logic alarm_valid;

  always_comb begin
    alarm_valid = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (alarm_sel == SEL_W'(i)) alarm_valid = 1'b1;
  end

  assign time_bcd  = {hour_to_12h(hour_q), min_q, sec_q};
  assign alarm_bcd = alarm_valid ?
                     {hour_to_12h(alarm_view[HOUR_OFS +: 8]), alarm_view[MIN_OFS +: 8], alarm_view[SEC_OFS +: 8]} :
                     24'h0;
  assign pm        = (hour_q >= 8'h12);
`else
  assign time_bcd  = time_q;
  assign alarm_bcd = alarm_view;
  assign pm        = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_clock_core.sv
// Self-checking bench for alarm_clock_core: directed scenarios plus random pulses,
// every cycle compared against a seconds/fields reference model.
module tb_alarm_clock_core;

  localparam int NA  = 4;
  localparam int SW  = 2;
  localparam int SNZ = 3;
  localparam int RTO = 5;

`ifdef ALARM_CLOCK_12H_EN
  localparam logic [7:0] H23 = 8'h11, H00 = 8'h12, H13 = 8'h01;
  localparam logic       PM13 = 1'b1;
`else
  localparam logic [7:0] H23 = 8'h23, H00 = 8'h00, H13 = 8'h13;
  localparam logic       PM13 = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1;
  logic          tick_1hz = 0, set_time = 0, up_sec = 0, up_min = 0, up_hour = 0;
  logic [SW-1:0] alarm_sel = '0;
  logic          alarm_up_sec = 0, alarm_up_min = 0, alarm_up_hour = 0;
  logic [NA-1:0] alarm_en = '0;
  logic          snooze = 0, dismiss = 0;
  logic [23:0]   time_bcd, alarm_bcd;
  logic          pm, ringing, snoozing;
  logic [SW-1:0] ring_id;
  logic [1:0]    state;
  logic [6:0]    status;

  alarm_clock_core #(.NUM_ALARMS(NA), .SEL_W(SW), .SNOOZE_SEC(SNZ), .RING_TIMEOUT(RTO)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_time(set_time),
    .up_sec(up_sec), .up_min(up_min), .up_hour(up_hour),
    .alarm_sel(alarm_sel), .alarm_up_sec(alarm_up_sec), .alarm_up_min(alarm_up_min),
    .alarm_up_hour(alarm_up_hour), .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
    .time_bcd(time_bcd), .alarm_bcd(alarm_bcd), .pm(pm), .ringing(ringing),
    .snoozing(snoozing), .ring_id(ring_id), .state(state));

  assign status = {ring_id, state, snoozing, ringing, pm};

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: plain integer fields, FSM state 0 idle / 1 ring / 2 snooze
  int m_h, m_m, m_s;
  int a_h[NA], a_m[NA], a_s[NA];
  int m_state, m_rid, m_ring_secs, m_snooze_left;
  bit m_adv;

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0;
    for (int i = 0; i < NA; i++) begin a_h[i] = 0; a_m[i] = 0; a_s[i] = 0; end
    m_state = 0; m_rid = 0; m_ring_secs = 0; m_snooze_left = 0; m_adv = 0;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [7:0] hour_disp(input int h);
`ifdef ALARM_CLOCK_12H_EN
    if (h == 0) return bcd(12);
    if (h > 12) return bcd(h - 12);
`endif
    return bcd(h);
  endfunction

  function automatic logic [23:0] exp_time();
    return {hour_disp(m_h), bcd(m_m), bcd(m_s)};
  endfunction

  function automatic logic [23:0] exp_alarm();
    int s = int'(alarm_sel);
    if (s >= NA) return 24'h0;
    return {hour_disp(a_h[s]), bcd(a_m[s]), bcd(a_s[s])};
  endfunction

  function automatic logic [6:0] exp_status();
    logic p;
`ifdef ALARM_CLOCK_12H_EN
    p = (m_h >= 12);
`else
    p = 1'b0;
`endif
    return {2'(m_rid), 2'(m_state), m_state == 2, m_state == 1, p};
  endfunction

  task automatic model_step();
    int hit, t, s;
    hit = -1;
    if (m_adv)
      for (int i = NA - 1; i >= 0; i--)
        if (alarm_en[i] && a_h[i] == m_h && a_m[i] == m_m && a_s[i] == m_s) hit = i;
    if (m_state == 0) begin
      if (hit >= 0) begin m_state = 1; m_rid = hit; m_ring_secs = 0; end
    end else if (dismiss || !alarm_en[m_rid]) begin
      m_state = 0;
    end else if (m_state == 1) begin
      if (snooze) begin
        m_state = 2; m_snooze_left = SNZ;
      end else if (tick_1hz) begin
        m_ring_secs++;
        if (m_ring_secs == RTO) m_state = 0;
      end
    end else if (tick_1hz) begin
      m_snooze_left--;
      if (m_snooze_left == 0) begin m_state = 1; m_ring_secs = 0; end
    end
    if (set_time) begin
      if (up_sec)  m_s = (m_s + 1) % 60;
      if (up_min)  m_m = (m_m + 1) % 60;
      if (up_hour) m_h = (m_h + 1) % 24;
    end else if (tick_1hz) begin
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
    end
    s = int'(alarm_sel);
    if (s < NA) begin
      if (alarm_up_sec)  a_s[s] = (a_s[s] + 1) % 60;
      if (alarm_up_min)  a_m[s] = (a_m[s] + 1) % 60;
      if (alarm_up_hour) a_h[s] = (a_h[s] + 1) % 24;
    end
    m_adv = tick_1hz && !set_time;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("time", time_bcd, exp_time());
    chk("alarm", alarm_bcd, exp_alarm());
    chk("status", status, exp_status());
    tick_1hz = 0; up_sec = 0; up_min = 0; up_hour = 0;
    alarm_up_sec = 0; alarm_up_min = 0; alarm_up_hour = 0;
    snooze = 0; dismiss = 0;
  endtask

  task automatic set_clock(input int h, input int m, input int s);
    int dh = (h - m_h + 24) % 24;
    int dm = (m - m_m + 60) % 60;
    int ds = (s - m_s + 60) % 60;
    set_time = 1;
    for (int i = 0; i < 60; i++) begin
      up_hour = (i < dh); up_min = (i < dm); up_sec = (i < ds);
      step();
    end
    set_time = 0;
  endtask

  task automatic set_alarm(input int idx, input int h, input int m, input int s);
    int dh = (h - a_h[idx] + 24) % 24;
    int dm = (m - a_m[idx] + 60) % 60;
    int ds = (s - a_s[idx] + 60) % 60;
    alarm_sel = SW'(idx);
    for (int i = 0; i < 60; i++) begin
      alarm_up_hour = (i < dh); alarm_up_min = (i < dm); alarm_up_sec = (i < ds);
      step();
    end
  endtask

  task automatic ring_from_0659();
    set_clock(6, 59, 59);
    tick_1hz = 1; step();
    chk("ring_t0", ringing, 1'b0);
    step();
    chk("ring_t1", ringing, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", time_bcd, 24'h0);
    chk("rst_alarm", alarm_bcd, 24'h0);
    chk("rst_status", status, 7'h0);
    reset = 0;

    // midnight rollover
    set_clock(23, 59, 58);
    tick_1hz = 1; step(); chk("wrap_a", time_bcd, {H23, 16'h5959});
    tick_1hz = 1; step(); chk("wrap_b", time_bcd, {H00, 16'h0000});

    // set mode: no carry, ticks ignored
    set_clock(0, 59, 30);
    set_time = 1; up_min = 1; step(); chk("set_min", time_bcd, {H00, 16'h0030});
    tick_1hz = 1; step(); chk("set_tick", time_bcd, {H00, 16'h0030});
    set_time = 0;

    // two alarms at the same time: lowest index rings
    set_alarm(1, 7, 0, 0);
    set_alarm(2, 7, 0, 0);
    chk("alarm2_view", alarm_bcd, 24'h070000);
    alarm_en = 4'b0110;
    ring_from_0659();
    chk("ring_id", ring_id, 2'd1);

    // snooze then re-ring after SNZ ticks, then snooze+dismiss together
    snooze = 1; step(); chk("snz_enter", snoozing, 1'b1);
    for (int k = 1; k <= SNZ; k++) begin
      tick_1hz = 1; step();
      chk("snz_ring", ringing, (k == SNZ) ? 1'b1 : 1'b0);
    end
    snooze = 1; dismiss = 1; step(); chk("snz_dis", state, 2'd0);

    // unacknowledged ring times out on the RTO-th tick
    ring_from_0659();
    for (int k = 1; k <= RTO; k++) begin
      tick_1hz = 1; step();
      chk("timeout", state, (k < RTO) ? 2'd1 : 2'd0);
    end

    // disabling the ringing alarm drops straight to idle
    ring_from_0659();
    alarm_en[1] = 1'b0; step(); chk("en_fall", state, 2'd0);
    alarm_en = 4'b0110;

    // hour display and pm
    set_clock(13, 5, 0);
    chk("h13_hr", time_bcd[23:16], H13);
    chk("h13_pm", pm, PM13);
    set_clock(0, 30, 0);
    chk("h00_hr", time_bcd[23:16], H00);
    chk("h00_pm", pm, 1'b0);

    // random traffic against the model
    alarm_en = '1;
    set_alarm(3, m_h, m_m, (m_s + 3) % 60);
    for (int c = 0; c < 3000; c++) begin
      tick_1hz = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) set_time = ~set_time;
      if (set_time) begin
        up_sec  = ($urandom_range(0, 3) == 0);
        up_min  = ($urandom_range(0, 3) == 0);
        up_hour = ($urandom_range(0, 3) == 0);
      end
      alarm_sel     = SW'($urandom);
      alarm_up_sec  = ($urandom_range(0, 39) == 0);
      alarm_up_min  = ($urandom_range(0, 39) == 0);
      alarm_up_hour = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) alarm_en = NA'($urandom);
      snooze  = ($urandom_range(0, 49) == 0);
      dismiss = ($urandom_range(0, 79) == 0);
      step();
    end

    // asynchronous reset clears everything without a clock edge
    reset = 1;
    #1;
    chk("async_rst_time", time_bcd, 24'h0);
    chk("async_rst_status", status, 7'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
